// File: rtl/demux_1to2_8bit_buf_if.sv
// Byte-stream bundle for the 1-to-2 demux: one upstream channel, two downstream channels.
// master = source/consumer side, slave = the demux itself.
interface demux_1to2_8bit_buf_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             din_ready;
    logic             sel;
    logic [WIDTH-1:0] y0;
    logic             y0_valid;
    logic             y0_ready;
    logic [WIDTH-1:0] y1;
    logic             y1_valid;
    logic             y1_ready;

    modport master (
        output din, din_valid, sel, y0_ready, y1_ready,
        input  din_ready, y0, y0_valid, y1, y1_valid
    );

    modport slave (
        input  din, din_valid, sel, y0_ready, y1_ready,
        output din_ready, y0, y0_valid, y1, y1_valid
    );
endinterface

// File: rtl/demux_1to2_8bit_buf.sv
// Steers a valid/ready byte stream to one of two per-channel FIFOs chosen by sel.
// Latency: 1 cycle from accept to y<sel>_valid; no bypass.
// Backpressure: din_ready = !full[sel] only; optional counters under DEMUX_COUNT_EN.

module demux_1to2_8bit_buf_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdat,
    input  logic             pop,
    output logic [WIDTH-1:0] rdat,
    output logic             full,
    output logic             empty
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    // Head is forced to zero while empty so stale storage never leaks out.
    assign rdat    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdat;
    end
endmodule

module demux_1to2_8bit_buf #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    demux_1to2_8bit_buf_if.slave bus
`ifdef DEMUX_COUNT_EN
    ,
    output logic [7:0]           cnt0,
    output logic [7:0]           cnt1
`endif
);
    logic full0;
    logic full1;
    logic empty0;
    logic empty1;
    logic accept;
    logic push0;
    logic push1;
    logic pop0;
    logic pop1;

    // Ready looks only at the addressed channel's registered occupancy.
    assign bus.din_ready = bus.sel ? !full1 : !full0;
    assign accept        = bus.din_valid && bus.din_ready;
    assign push0         = accept && !bus.sel;
    assign push1         = accept && bus.sel;

    assign bus.y0_valid  = !empty0;
    assign bus.y1_valid  = !empty1;
    assign pop0          = bus.y0_valid && bus.y0_ready;
    assign pop1          = bus.y1_valid && bus.y1_ready;

    demux_1to2_8bit_buf_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo0 (
        .clk   (clk),
        .rst   (rst),
        .push  (push0),
        .wdat  (bus.din),
        .pop   (pop0),
        .rdat  (bus.y0),
        .full  (full0),
        .empty (empty0)
    );

    demux_1to2_8bit_buf_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo1 (
        .clk   (clk),
        .rst   (rst),
        .push  (push1),
        .wdat  (bus.din),
        .pop   (pop1),
        .rdat  (bus.y1),
        .full  (full1),
        .empty (empty1)
    );

`ifdef DEMUX_COUNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt0 <= 8'd0;
            cnt1 <= 8'd0;
        end else begin
            if (push0) cnt0 <= cnt0 + 8'd1;
            if (push1) cnt1 <= cnt1 + 8'd1;
        end
    end
`endif
endmodule

// File: tb/tb_demux_1to2_8bit_buf.sv
// Bench for demux_1to2_8bit_buf: directed vector table, reset/counter sequences,
// then constrained-random traffic, all scored against a per-channel queue model.
module tb_demux_1to2_8bit_buf;
    localparam int WIDTH = 8;
    localparam int DEPTH = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    demux_1to2_8bit_buf_if #(.WIDTH(WIDTH)) bus ();

`ifdef DEMUX_COUNT_EN
    logic [7:0] cnt0;
    logic [7:0] cnt1;
    logic [7:0] cnt0_m = 8'd0;
    logic [7:0] cnt1_m = 8'd0;
`endif

    demux_1to2_8bit_buf #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus)
`ifdef DEMUX_COUNT_EN
        ,
        .cnt0 (cnt0),
        .cnt1 (cnt1)
`endif
    );

    int total = 0;
    int bad   = 0;
    logic [7:0] q0[$];
    logic [7:0] q1[$];
    logic stalled = 1'b0;
    int   n_acc0  = 0;

    typedef struct {
        logic       sel;
        logic       vld;
        logic [7:0] dat;
        logic       r0;
        logic       r1;
        logic       e_rdy;
        logic       e_v0;
        logic       e_v1;
    } vec_t;
    vec_t vt[24];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Model step at the falling edge: compare outputs with the queues, then
    // apply the pops and the push that the coming rising edge will perform.
    task automatic sb_step();
        logic exp_rdy;
        check("y0_valid", 32'(bus.y0_valid), 32'(q0.size() != 0));
        if (q0.size() != 0) check("y0", 32'(bus.y0), 32'(q0[0]));
        else                check("y0_idle", 32'(bus.y0), 32'h0);
        check("y1_valid", 32'(bus.y1_valid), 32'(q1.size() != 0));
        if (q1.size() != 0) check("y1", 32'(bus.y1), 32'(q1[0]));
        else                check("y1_idle", 32'(bus.y1), 32'h0);
        exp_rdy = bus.sel ? (q1.size() < DEPTH) : (q0.size() < DEPTH);
        check("din_ready", 32'(bus.din_ready), 32'(exp_rdy));
`ifdef DEMUX_COUNT_EN
        check("cnt0", 32'(cnt0), 32'(cnt0_m));
        check("cnt1", 32'(cnt1), 32'(cnt1_m));
`endif
        if (q0.size() != 0 && bus.y0_ready) void'(q0.pop_front());
        if (q1.size() != 0 && bus.y1_ready) void'(q1.pop_front());
        if (bus.din_valid && exp_rdy) begin
            if (bus.sel) begin
                q1.push_back(bus.din);
`ifdef DEMUX_COUNT_EN
                cnt1_m = cnt1_m + 8'd1;
`endif
            end else begin
                q0.push_back(bus.din);
                n_acc0++;
`ifdef DEMUX_COUNT_EN
                cnt0_m = cnt0_m + 8'd1;
`endif
            end
        end
        stalled = bus.din_valid && !exp_rdy;
    endtask

    task automatic step();
        @(negedge clk);
        sb_step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic s, input logic v, input logic [7:0] d, input logic r0, input logic r1);
        bus.sel       = s;
        bus.din_valid = v;
        bus.din       = d;
        bus.y0_ready  = r0;
        bus.y1_ready  = r1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        //          sel vld dat    r0 r1 rdy v0 v1
        vt[0]  = '{1'b0, 1'b1, 8'hA5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vt[1]  = '{1'b1, 1'b1, 8'h3C, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        vt[2]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        vt[3]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vt[4]  = '{1'b0, 1'b1, 8'h11, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vt[5]  = '{1'b0, 1'b1, 8'h22, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        vt[6]  = '{1'b0, 1'b1, 8'h33, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        vt[7]  = '{1'b0, 1'b1, 8'h33, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        vt[8]  = '{1'b0, 1'b1, 8'h33, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        vt[9]  = '{1'b0, 1'b1, 8'h33, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        vt[10] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        vt[11] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vt[12] = '{1'b0, 1'b1, 8'h66, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vt[13] = '{1'b0, 1'b1, 8'h67, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        vt[14] = '{1'b1, 1'b1, 8'h77, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        vt[15] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        vt[16] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        vt[17] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        vt[18] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vt[19] = '{1'b1, 1'b1, 8'h44, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        vt[20] = '{1'b1, 1'b1, 8'h55, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        vt[21] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        vt[22] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        vt[23] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        rst = 1'b1;
        #2;
        check("rst_y0_valid", 32'(bus.y0_valid), 32'h0);
        check("rst_y1_valid", 32'(bus.y1_valid), 32'h0);
        check("rst_y0", 32'(bus.y0), 32'h0);
        check("rst_y1", 32'(bus.y1), 32'h0);
        check("rst_din_ready", 32'(bus.din_ready), 32'h1);
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < 24; i++) begin
            drive(vt[i].sel, vt[i].vld, vt[i].dat, vt[i].r0, vt[i].r1);
            @(negedge clk);
            sb_step();
            check($sformatf("row%0d_din_ready", i), 32'(bus.din_ready), 32'(vt[i].e_rdy));
            check($sformatf("row%0d_y0_valid", i), 32'(bus.y0_valid), 32'(vt[i].e_v0));
            check($sformatf("row%0d_y1_valid", i), 32'(bus.y1_valid), 32'(vt[i].e_v1));
            @(posedge clk);
            #1;
        end

        // Asynchronous reset with channel 0 full and stalled.
        drive(1'b0, 1'b1, 8'hC1, 1'b0, 1'b0);
        step();
        drive(1'b0, 1'b1, 8'hC2, 1'b0, 1'b0);
        step();
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        check("pre_rst_din_ready", 32'(bus.din_ready), 32'h0);
        #1;
        rst = 1'b1;
        #1;
        check("arst_y0_valid", 32'(bus.y0_valid), 32'h0);
        check("arst_y1_valid", 32'(bus.y1_valid), 32'h0);
        check("arst_y0", 32'(bus.y0), 32'h0);
        check("arst_din_ready", 32'(bus.din_ready), 32'h1);
`ifdef DEMUX_COUNT_EN
        check("arst_cnt0", 32'(cnt0), 32'h0);
        check("arst_cnt1", 32'(cnt1), 32'h0);
        cnt0_m = 8'd0;
        cnt1_m = 8'd0;
`endif
        #1;
        rst = 1'b0;
        q0.delete();
        q1.delete();
        stalled = 1'b0;
        n_acc0  = 0;

`ifdef DEMUX_COUNT_EN
        begin
            int cyc;
            cyc = 0;
            while (n_acc0 < 256 && cyc < 2000) begin
                drive(1'b0, 1'b1, 8'(cyc), 1'b1, 1'b1);
                step();
                cyc++;
            end
            check("cnt_accepts_in_budget", 32'(n_acc0), 32'd256);
            drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
            step();
            check("cnt0_wrap", 32'(cnt0), 32'h0);
            check("cnt1_untouched", 32'(cnt1), 32'h0);
        end
`endif

        for (int c = 0; c < 400; c++) begin
            if (!stalled) begin
                bus.din_valid = ($urandom_range(0, 3) != 0);
                bus.sel       = 1'($urandom_range(0, 1));
                bus.din       = 8'($urandom_range(0, 255));
            end
            bus.y0_ready = ($urandom_range(0, 2) != 0);
            bus.y1_ready = ($urandom_range(0, 2) != 0);
            step();
        end

        drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        for (int c = 0; c < 6; c++) step();
        check("drain_y0_valid", 32'(bus.y0_valid), 32'h0);
        check("drain_y1_valid", 32'(bus.y1_valid), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
